// File: rtl/sc_shiftsched_if.sv
// rtl/sc_shiftsched_if.sv - command handshake and shifter control bundle for sc_shiftsched
interface sc_shiftsched_if #(
    parameter int COUNT_WIDTH = 4
);
    logic                   SC_SHIFTSCHED_cmd_valid_In;
    logic                   SC_SHIFTSCHED_cmd_ready_Out;
    logic [1:0]             SC_SHIFTSCHED_cmd_op_In;
    logic [COUNT_WIDTH-1:0] SC_SHIFTSCHED_cmd_count_In;
    logic                   SC_SHIFTSCHED_clear_OutLow;
    logic                   SC_SHIFTSCHED_load_OutLow;
    logic [1:0]             SC_SHIFTSCHED_shiftselection_Out;
    logic                   SC_SHIFTSCHED_busy_Out;
    logic                   SC_SHIFTSCHED_done_Out;

    modport master (
        output SC_SHIFTSCHED_cmd_valid_In,
        output SC_SHIFTSCHED_cmd_op_In,
        output SC_SHIFTSCHED_cmd_count_In,
        input  SC_SHIFTSCHED_cmd_ready_Out,
        input  SC_SHIFTSCHED_clear_OutLow,
        input  SC_SHIFTSCHED_load_OutLow,
        input  SC_SHIFTSCHED_shiftselection_Out,
        input  SC_SHIFTSCHED_busy_Out,
        input  SC_SHIFTSCHED_done_Out
    );

    modport slave (
        input  SC_SHIFTSCHED_cmd_valid_In,
        input  SC_SHIFTSCHED_cmd_op_In,
        input  SC_SHIFTSCHED_cmd_count_In,
        output SC_SHIFTSCHED_cmd_ready_Out,
        output SC_SHIFTSCHED_clear_OutLow,
        output SC_SHIFTSCHED_load_OutLow,
        output SC_SHIFTSCHED_shiftselection_Out,
        output SC_SHIFTSCHED_busy_Out,
        output SC_SHIFTSCHED_done_Out
    );
endinterface

// File: rtl/sc_shiftsched.sv
// rtl/sc_shiftsched.sv - command scheduler issuing clear/load/shift pulses to the register shifter
// Optional abort input enabled by defining SC_SHIFTSCHED_ABORT_EN.
module sc_shiftsched #(
    parameter int COUNT_WIDTH = 4,
    parameter int TICK_PERIOD = 50000
) (
    input  logic SC_SHIFTSCHED_CLOCK_50,
    input  logic SC_SHIFTSCHED_RESET_InLow,
`ifdef SC_SHIFTSCHED_ABORT_EN
    input  logic SC_SHIFTSCHED_abort_InLow,
`endif
    sc_shiftsched_if.slave bus
);

    localparam int TICK_WIDTH = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TICK_WIDTH-1:0]  TICK_LAST = TICK_WIDTH'(TICK_PERIOD - 2);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_SHIFTR = 2'b01;
    localparam logic [1:0] OP_SHIFTL = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [TICK_WIDTH-1:0]   tick_q, tick_d;
    logic                    abort_req;
    logic                    op_is_shift;

`ifdef SC_SHIFTSCHED_ABORT_EN
    assign abort_req = ~SC_SHIFTSCHED_abort_InLow;
`else
    assign abort_req = 1'b0;
`endif

    assign op_is_shift = (op_q == OP_SHIFTR) || (op_q == OP_SHIFTL);

    always_ff @(posedge SC_SHIFTSCHED_CLOCK_50 or negedge SC_SHIFTSCHED_RESET_InLow) begin
        if (!SC_SHIFTSCHED_RESET_InLow) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            remaining_q <= '0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        tick_d      = tick_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.SC_SHIFTSCHED_cmd_valid_In) begin
                    op_d   = bus.SC_SHIFTSCHED_cmd_op_In;
                    tick_d = '0;
                    if ((bus.SC_SHIFTSCHED_cmd_op_In == OP_CLEAR) ||
                        (bus.SC_SHIFTSCHED_cmd_op_In == OP_LOAD)) begin
                        remaining_d = '0;
                        state_d     = S_ISSUE;
                    end else begin
                        remaining_d = bus.SC_SHIFTSCHED_cmd_count_In;
                        state_d     = (bus.SC_SHIFTSCHED_cmd_count_In == '0) ? S_DONE : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The pulse for this cycle is already on the outputs; abort only stops later ones.
                tick_d = '0;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - COUNT_ONE;
                end
                if (!op_is_shift || (remaining_q <= COUNT_ONE) || abort_req) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (tick_q == TICK_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    tick_d = tick_q + TICK_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, so no input reaches an output combinationally.
    assign bus.SC_SHIFTSCHED_cmd_ready_Out = (state_q == S_IDLE);
    assign bus.SC_SHIFTSCHED_busy_Out      = (state_q != S_IDLE);
    assign bus.SC_SHIFTSCHED_done_Out      = (state_q == S_DONE);
    assign bus.SC_SHIFTSCHED_clear_OutLow  = !((state_q == S_ISSUE) && (op_q == OP_CLEAR));
    assign bus.SC_SHIFTSCHED_load_OutLow   = !((state_q == S_ISSUE) && (op_q == OP_LOAD));
    assign bus.SC_SHIFTSCHED_shiftselection_Out =
        ((state_q == S_ISSUE) && op_is_shift) ? op_q : SEL_HOLD;

endmodule

// File: tb/tb_sc_shiftsched.sv
// tb/tb_sc_shiftsched.sv - self-checking bench for sc_shiftsched against a timing-formula model
module tb_sc_shiftsched;
    localparam int TP = 4;
    localparam int CW = 4;
    localparam logic [6:0] IDLE_OUT = 7'b1001111;

    logic clk = 1'b0;
    logic rst_n;
`ifdef SC_SHIFTSCHED_ABORT_EN
    logic abort_n;
`endif

    sc_shiftsched_if #(.COUNT_WIDTH(CW)) bus ();

    sc_shiftsched #(.COUNT_WIDTH(CW), .TICK_PERIOD(TP)) dut (
        .SC_SHIFTSCHED_CLOCK_50   (clk),
        .SC_SHIFTSCHED_RESET_InLow(rst_n),
`ifdef SC_SHIFTSCHED_ABORT_EN
        .SC_SHIFTSCHED_abort_InLow(abort_n),
`endif
        .bus                      (bus)
    );

    always #10 clk = ~clk;

    int   checks;
    int   errors;
    int   cur;
    int   m_t;
    int   m_end;
    logic [1:0] m_op;
    int   pulses;
    logic accepted;

    // Expected {ready, busy, done, clear_n, load_n, sel} for cycle c, from the command timing rules.
    function automatic logic [6:0] model_out(input int c);
        logic       rdy = 1'b1;
        logic       bsy = 1'b0;
        logic       dn  = 1'b0;
        logic       cl  = 1'b1;
        logic       ld  = 1'b1;
        logic [1:0] sel = 2'b11;
        if (c > m_t && c <= m_end) begin
            rdy = 1'b0;
            bsy = 1'b1;
            dn  = (c == m_end);
            if (c < m_end) begin
                if (m_op == 2'b00) cl = 1'b0;
                else if (m_op == 2'b11) ld = 1'b0;
                else if (((c - m_t - 1) % TP) == 0) sel = m_op;
            end
        end
        return {rdy, bsy, dn, cl, ld, sel};
    endfunction

    function automatic logic [6:0] dut_out();
        return {bus.SC_SHIFTSCHED_cmd_ready_Out, bus.SC_SHIFTSCHED_busy_Out,
                bus.SC_SHIFTSCHED_done_Out, bus.SC_SHIFTSCHED_clear_OutLow,
                bus.SC_SHIFTSCHED_load_OutLow, bus.SC_SHIFTSCHED_shiftselection_Out};
    endfunction

    task automatic check_vec(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cur, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cur, got, exp);
        end
    endtask

    // Called at a falling edge: check this cycle, update the model, drive inputs, advance one cycle.
    task automatic step(input logic v, input logic [1:0] op, input logic [CW-1:0] cnt, input logic ab);
        logic [6:0] got;
        logic [6:0] exp;
        got = dut_out();
        exp = model_out(cur);
        check_vec("outputs", got, exp);
        if (got[1:0] != 2'b11 || !got[3] || !got[2]) pulses++;
        accepted = 1'b0;
        if (v && exp[6] && rst_n) begin
            m_t  = cur;
            m_op = op;
            if (op == 2'b00 || op == 2'b11) m_end = cur + 2;
            else if (cnt == '0)             m_end = cur + 1;
            else                            m_end = cur + 1 + (int'(cnt) - 1) * TP + 1;
            accepted = 1'b1;
        end
`ifdef SC_SHIFTSCHED_ABORT_EN
        if (!ab && cur > m_t && cur < m_end) m_end = cur + 1;
        abort_n = ab;
`else
        if (!ab) pulses = pulses + 0;
`endif
        bus.SC_SHIFTSCHED_cmd_valid_In = v;
        bus.SC_SHIFTSCHED_cmd_op_In    = op;
        bus.SC_SHIFTSCHED_cmd_count_In = cnt;
        @(posedge clk);
        cur++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 1'b1);
    endtask

    task automatic drain();
        int guard = 0;
        while (!model_out(cur)[6] && guard < 200) begin
            step(1'b0, 2'b00, '0, 1'b1);
            guard++;
        end
        check_int("drain_timeout", int'(guard < 200), 1);
    endtask

    initial begin
        int e;
        checks = 0;
        errors = 0;
        cur    = 0;
        m_t    = -100;
        m_end  = -100;
        m_op   = 2'b11;
        pulses = 0;
        rst_n  = 1'b0;
`ifdef SC_SHIFTSCHED_ABORT_EN
        abort_n = 1'b1;
`endif
        bus.SC_SHIFTSCHED_cmd_valid_In = 1'b0;
        bus.SC_SHIFTSCHED_cmd_op_In    = 2'b00;
        bus.SC_SHIFTSCHED_cmd_count_In = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("reset_hold", dut_out(), IDLE_OUT);
        end
        rst_n = 1'b1;
        idle(2);

        // Load: single load pulse at T+1, done at T+2
        step(1'b1, 2'b11, 4'd7, 1'b1);
        pulses = 0;
        idle(4);
        check_int("load_pulses", pulses, 1);

        // Shift right x3: pulses at T+1, T+5, T+9
        step(1'b1, 2'b01, 4'd3, 1'b1);
        pulses = 0;
        idle(12);
        check_int("shr3_pulses", pulses, 3);

        // Shift left with zero count: straight to done
        step(1'b1, 2'b10, 4'd0, 1'b1);
        pulses = 0;
        idle(3);
        check_int("shl0_pulses", pulses, 0);

        // Clear
        step(1'b1, 2'b00, 4'd9, 1'b1);
        pulses = 0;
        idle(3);
        check_int("clear_pulses", pulses, 1);

        // Valid held high throughout a count=2 shift
        step(1'b1, 2'b01, 4'd2, 1'b1);
        e = m_end;
        pulses = 0;
        while (cur <= e) step(1'b1, 2'b10, 4'd1, 1'b1);
        check_int("held_valid_pulses", pulses, 2);
        step(1'b1, 2'b10, 4'd1, 1'b1);
        check_int("held_valid_next_accept", int'(accepted), 1);
        drain();

        // Reset two cycles after the 2nd pulse of a count=5 shift
        step(1'b1, 2'b01, 4'd5, 1'b1);
        idle(6);
        check_vec("pre_reset_wait", dut_out(), model_out(cur));
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_idle", dut_out(), IDLE_OUT);
        m_end = m_t;
        pulses = 0;
        idle(2);
        rst_n = 1'b1;
        idle(30);
        check_int("post_reset_pulses", pulses, 0);

`ifdef SC_SHIFTSCHED_ABORT_EN
        // Abort at the first WAIT cycle of a count=5 shift
        step(1'b1, 2'b01, 4'd5, 1'b1);
        pulses = 0;
        step(1'b0, 2'b00, '0, 1'b1);
        step(1'b0, 2'b00, '0, 1'b0);
        check_int("abort_done", int'(bus.SC_SHIFTSCHED_done_Out), 1);
        idle(8);
        check_int("abort_pulses", pulses, 1);
`endif

        // Randomized commands, with input noise while busy
        for (int n = 0; n < 40; n++) begin
            logic [1:0]    op;
            logic [CW-1:0] cnt;
            idle($urandom_range(0, 2));
            op  = 2'($urandom);
            cnt = ($urandom % 4 == 0) ? CW'($urandom_range(7, 15)) : CW'($urandom_range(0, 3));
            step(1'b1, op, cnt, 1'b1);
            check_int("rand_accept", int'(accepted), 1);
            for (int g = 0; g < 200 && !model_out(cur)[6]; g++)
                step(1'($urandom), 2'($urandom), CW'($urandom), ($urandom % 10) != 0);
            check_int("rand_complete", int'(model_out(cur)[6]), 1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
